digit_serial_subtractor: RTL and testbench

Parametrised multi-cycle unsigned subtractor. Computes d = a - b - bin over WIDTH bits, DIGIT bits per clock, using a registered borrow between digits. Trades latency for area against the combinational ripple-borrow subtractor. Uses a start/busy/done handshake and sits beside the datapath ALU as the wide-operand subtract unit.

---
 rtl/digit_serial_subtractor.sv | 130 +++++++++++++
 tb/tb_digit_serial_subtractor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle unsigned subtractor: d = a - b - bin, DIGIT bits per clock.
// Ports: clk, rst_n, start/a/b/bin in; busy, done, d, bout out. Macro: SUB_SATURATE_EN.
module digit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic [DIGIT-1:0] dig_c;
  logic             brw_c;
  logic [WIDTH-1:0] acc_nx;
  logic             last;

  // Ripple borrow through the current (lowest) digit of the operands.
  always_comb begin
    dig_c = '0;
    brw_c = brw_q;
    for (int i = 0; i < DIGIT; i++) begin
      dig_c[i] = a_q[i] ^ b_q[i] ^ brw_c;
      brw_c = (~a_q[i] & b_q[i]) | ((~a_q[i] | b_q[i]) & brw_c);
    end
  end

  // Result digits enter at the top and shift down; after N steps
  // the first digit lands in bit 0.
  assign acc_nx = (acc_q >> DIGIT)
                | (WIDTH'(dig_c) << (WIDTH - DIGIT));
  assign last   = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        brw_d = brw_c;
        acc_d = acc_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bout_d  = brw_c;
          cnt_d   = '0;
`ifdef SUB_SATURATE_EN
          d_d = brw_c ? '0 : acc_nx;
`else
          d_d = acc_nx;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Bench for digit_serial_subtractor: directed cases, handshake corners,
// mid-run reset, and random sweeps over four WIDTH/DIGIT builds.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  st = '0;
  logic [15:0] ta = '0;
  logic [15:0] tbv = '0;
  logic        tbin = 1'b0;

  logic        m_busy, m_done, m_bout;
  logic [7:0]  m_d;
  logic        s1_busy, s1_done, s1_bout;
  logic [7:0]  s1_d;
  logic        s2_busy, s2_done, s2_bout;
  logic [7:0]  s2_d;
  logic        s3_busy, s3_done, s3_bout;
  logic [15:0] s3_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_m (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
    .a(ta[7:0]), .b(tbv[7:0]), .bin(tbin),
    .busy(m_busy), .done(m_done), .d(m_d), .bout(m_bout));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
    .a(ta[7:0]), .b(tbv[7:0]), .bin(tbin),
    .busy(s1_busy), .done(s1_done), .d(s1_d), .bout(s1_bout));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
    .a(ta[7:0]), .b(tbv[7:0]), .bin(tbin),
    .busy(s2_busy), .done(s2_done), .d(s2_d), .bout(s2_bout));

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]),
    .a(ta), .b(tbv), .bin(tbin),
    .busy(s3_busy), .done(s3_done), .d(s3_d), .bout(s3_bout));

  function automatic int w_of(input int k);
    return (k == 3) ? 16 : 8;
  endfunction

  function automatic int n_of(input int k);
    case (k)
      1: return 8;
      2: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic get_busy(input int k);
    case (k)
      1: return s1_busy;
      2: return s2_busy;
      3: return s3_busy;
      default: return m_busy;
    endcase
  endfunction

  function automatic logic get_done(input int k);
    case (k)
      1: return s1_done;
      2: return s2_done;
      3: return s3_done;
      default: return m_done;
    endcase
  endfunction

  function automatic logic [15:0] get_d(input int k);
    case (k)
      1: return {8'h00, s1_d};
      2: return {8'h00, s2_d};
      3: return s3_d;
      default: return {8'h00, m_d};
    endcase
  endfunction

  function automatic logic get_bout(input int k);
    case (k)
      1: return s1_bout;
      2: return s2_bout;
      3: return s3_bout;
      default: return m_bout;
    endcase
  endfunction

  // Reference: plain signed arithmetic on the operand values.
  function automatic void model(input int w, input longint av,
                                input longint bv, input longint cv,
                                output logic [15:0] de, output logic be);
    longint diff;
    longint m;
    diff = av - bv - cv;
    m    = (longint'(1) << w);
    be   = (diff < 0);
    de   = 16'(((diff % m) + m) % m);
`ifdef SUB_SATURATE_EN
    if (be) de = '0;
`endif
  endfunction

  // Runs one operation on instance k; returns observations only.
  task automatic run_op(input int k, input logic [15:0] av,
                        input logic [15:0] bv, input logic cv,
                        output logic [15:0] dobs, output logic bobs,
                        output int lat, output bit busy_ok);
    ta = av; tbv = bv; tbin = cv;
    st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    ta = 16'($urandom); tbv = 16'($urandom); tbin = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    while (!get_done(k) && lat < 64) begin
      if (!get_busy(k)) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (get_busy(k)) busy_ok = 1'b0;
    dobs = get_d(k);
    bobs = get_bout(k);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs busy=%b done=%b want 0 0", m_busy, m_done);
    end
    checks++;
    if (m_d !== 8'h00 || m_bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_data d=%h bout=%b want 00 0", m_d, m_bout);
    end
    checks++;
    if (s3_d !== 16'h0 || s3_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_w16 d=%h busy=%b want 0 0", s3_d, s3_busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [7:0] va [5] = '{8'h5A, 8'h10, 8'h00, 8'h00, 8'hFF};
    logic [7:0] vb [5] = '{8'h3C, 8'h20, 8'h00, 8'h01, 8'hFF};
    logic       vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SUB_SATURATE_EN
    logic [7:0] vd [5] = '{8'h1E, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    logic [7:0] vd [5] = '{8'h1E, 8'hF0, 8'hFF, 8'hFF, 8'h00};
`endif
    logic       vo [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] dobs;
    logic        bobs;
    int          lat;
    bit          bok;
    for (int i = 0; i < 5; i++) begin
      run_op(0, {8'h00, va[i]}, {8'h00, vb[i]}, vc[i],
             dobs, bobs, lat, bok);
      checks++;
      if (dobs[7:0] !== vd[i] || bobs !== vo[i]) begin
        errors++;
        $display("FAIL dir%0d d=%h bout=%b want %h %b",
                 i, dobs[7:0], bobs, vd[i], vo[i]);
      end
      checks++;
      if (lat != 4 || !bok) begin
        errors++;
        $display("FAIL dir%0d_lat lat=%0d busy_ok=%0b want 4 1",
                 i, lat, bok);
      end
      @(posedge clk); #1;
      checks++;
      if (m_done !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_pulse done=%b want 0", i, m_done);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    ta = 16'h005A; tbv = 16'h003C; tbin = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b1; ta = 16'h0001; tbv = 16'h0001;
    @(posedge clk); #1;
    st[0] = 1'b0; ta = 16'h00C3;
    n = 2;
    while (!m_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 4 || m_d !== 8'h1E || m_bout !== 1'b0) begin
      errors++;
      $display("FAIL ign_first lat=%0d d=%h bout=%b want 4 1e 0",
               n, m_d, m_bout);
    end
    st[0] = 1'b1; ta = 16'h0001; tbv = 16'h0001; tbin = 1'b0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    checks++;
    if (m_busy !== 1'b1 || m_d !== 8'h1E) begin
      errors++;
      $display("FAIL b2b_accept busy=%b d=%h want 1 1e", m_busy, m_d);
    end
    n = 0;
    while (!m_done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 4 || m_d !== 8'h00 || m_bout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second lat=%0d d=%h bout=%b want 4 00 0",
               n, m_d, m_bout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] dobs;
    logic        bobs;
    int          lat;
    int          pulses;
    bit          bok;
    run_op(0, 16'h005A, 16'h003C, 1'b0, dobs, bobs, lat, bok);
    ta = 16'h0010; tbv = 16'h0020; tbin = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_busy !== 1'b0 || m_done !== 1'b0 ||
        m_d !== 8'h00 || m_bout !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid busy=%b done=%b d=%h bout=%b want 0 0 00 0",
               m_busy, m_done, m_d, m_bout);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_done) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL rst_nodone pulses=%0d want 0", pulses);
    end
    run_op(0, 16'h00FF, 16'h0001, 1'b0, dobs, bobs, lat, bok);
    checks++;
    if (dobs[7:0] !== 8'hFE || bobs !== 1'b0 || lat != 4) begin
      errors++;
      $display("FAIL rst_after d=%h bout=%b lat=%0d want fe 0 4",
               dobs[7:0], bobs, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int k, input int ops);
    logic [15:0] av, bv, de, dobs;
    logic        cv, be, bobs;
    int          lat, w;
    bit          bok;
    w = w_of(k);
    for (int i = 0; i < ops; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      if (w == 8) begin
        av[15:8] = '0;
        bv[15:8] = '0;
      end
      if (i % 16 == 0) bv = av;
      cv = 1'($urandom);
      model(w, longint'(av), longint'(bv), longint'(cv), de, be);
      run_op(k, av, bv, cv, dobs, bobs, lat, bok);
      checks++;
      if (dobs !== de || bobs !== be) begin
        errors++;
        $display("FAIL rnd_k%0d a=%h b=%h bin=%b d=%h bout=%b want %h %b",
                 k, av, bv, cv, dobs, bobs, de, be);
      end
      checks++;
      if (lat != n_of(k) || !bok) begin
        errors++;
        $display("FAIL rnd_k%0d_lat lat=%0d busy_ok=%0b want %0d 1",
                 k, lat, bok, n_of(k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_random(0, 200);
    test_random(1, 1000);
    test_random(2, 1000);
    test_random(3, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
